dmem_responder: RTL and testbench

//  Memory-side responder for the processor data port. Accepts one load/store request
//  per valid/ready handshake and performs it after a fixed LATENCY, then holds a

---
 rtl/dmem_pkg.sv | 15 +
 rtl/dmem_responder_if.sv | 26 ++
 rtl/dmem_ram.sv | 25 ++
 rtl/dmem_responder.sv | 108 ++++++++++
 tb/tb_dmem_responder.sv | 258 +++++++++++++++++++++++++
 5 files changed

// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory responder.
// Word width, alignment mask, FSM states and the address-range check.
package dmem_pkg;

    localparam int unsigned WORD_W = 32;
    localparam logic [WORD_W-1:0] ALIGN_MASK = 32'h0000_0003;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} dmem_state_t;

    // aw = log2(DEPTH); anything above the word index or below word alignment is an error
    function automatic logic addr_err(input logic [WORD_W-1:0] addr, input int unsigned aw);
        return ((addr & ALIGN_MASK) != '0) || ((addr >> (aw + 2)) != '0);
    endfunction

endpackage

// File: rtl/dmem_responder_if.sv
// Processor data-port bundle: request channel and response channel.
// The processor side is the master, the memory responder is the slave.
interface dmem_responder_if;
    import dmem_pkg::*;

    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [WORD_W-1:0] req_addr;
    logic [WORD_W-1:0] req_wdata;
    logic              resp_valid;
    logic              resp_ready;
    logic [WORD_W-1:0] resp_rdata;
    logic              resp_err;

    modport master (
        output req_valid, req_we, req_addr, req_wdata, resp_ready,
        input  req_ready, resp_valid, resp_rdata, resp_err
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, resp_ready,
        output req_ready, resp_valid, resp_rdata, resp_err
    );

endinterface

// File: rtl/dmem_ram.sv
// Single-port word RAM: synchronous write, combinational read.
// Contents are deliberately not reset.
module dmem_ram
    import dmem_pkg::*;
#(
    parameter int unsigned DEPTH = 64
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] idx,
    input  logic [WORD_W-1:0]        wdata,
    output logic [WORD_W-1:0]        rdata
);

    logic [WORD_W-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[idx] <= wdata;
        end
    end

    assign rdata = mem_q[idx];

endmodule

// File: rtl/dmem_responder.sv
// Memory-side responder for the processor data port: one request per handshake,
// performed after a fixed LATENCY, response held until the processor takes it.
//
//   state | meaning
//   IDLE  | ready for a request; accept latches we/addr/wdata and loads the timer
//   WAIT  | latency timer running; access performed when the timer reaches 0
//   RESP  | response presented and held until resp_ready
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int unsigned DEPTH   = 64,
    parameter int unsigned LATENCY = 2
) (
    input logic              clk,
    input logic              reset,
    dmem_responder_if.slave  bus
);

    localparam int unsigned AW    = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(LATENCY + 1);

    dmem_state_t       state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              we_q, we_d;
    logic [WORD_W-1:0] addr_q, addr_d;
    logic [WORD_W-1:0] wdata_q, wdata_d;
    logic [WORD_W-1:0] rdata_q, rdata_d;
    logic              err_q, err_d;

    logic              acc_err;
    logic              ram_we;
    logic [WORD_W-1:0] ram_rdata;

    assign acc_err = addr_err(addr_q, AW);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        ram_we  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.req_valid) begin
                    we_d    = bus.req_we;
                    addr_d  = bus.req_addr;
                    wdata_d = bus.req_wdata;
                    cnt_d   = CNT_W'(LATENCY - 1);
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (cnt_q == '0) begin
                    err_d   = acc_err;
                    ram_we  = we_q & ~acc_err;
                    rdata_d = acc_err ? '0 : (we_q ? wdata_q : ram_rdata);
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            RESP: begin
                if (bus.resp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    // A store whose final WAIT edge coincides with reset is aborted, so gate the write.
    dmem_ram #(.DEPTH(DEPTH)) u_ram (
        .clk   (clk),
        .we    (ram_we & ~reset),
        .idx   (addr_q[AW+1:2]),
        .wdata (wdata_q),
        .rdata (ram_rdata)
    );

    assign bus.req_ready  = (state_q == IDLE) & ~reset;
    assign bus.resp_valid = (state_q == RESP);
    assign bus.resp_rdata = rdata_q;
    assign bus.resp_err   = err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: directed scenarios plus randomized traffic
// compared every cycle against a timestamp-based behavioural model.
`timescale 1ns/1ps
module tb_dmem_responder;

    localparam int unsigned DEPTH = 64;
    localparam int unsigned LAT   = 2;
    localparam int unsigned LAT_B = 1;

    logic clk = 1'b0;
    logic reset;
    logic reset_b;
    always #5 clk = ~clk;

    dmem_responder_if bus ();
    dmem_responder_if bus_b ();

    dmem_responder #(.DEPTH(DEPTH), .LATENCY(LAT)) dut (
        .clk(clk), .reset(reset), .bus(bus)
    );
    dmem_responder #(.DEPTH(DEPTH), .LATENCY(LAT_B)) dut_b (
        .clk(clk), .reset(reset_b), .bus(bus_b)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [31:0] m_mem [DEPTH];
    bit          m_idle = 1'b1;
    bit          m_pend = 1'b0;
    bit          m_show = 1'b0;
    int          m_due  = 0;
    int          cyc    = 0;
    logic        m_we;
    logic [31:0] m_addr, m_wd;
    logic [31:0] m_rdata = '0;
    logic        m_err   = 1'b0;
    bit          cmp_on  = 1'b0;

    always @(posedge clk) begin
        cyc++;
        if (reset) begin
            m_idle = 1'b1; m_pend = 1'b0; m_show = 1'b0;
            m_rdata = '0; m_err = 1'b0;
        end else if (m_idle) begin
            if (bus.req_valid) begin
                m_idle = 1'b0; m_pend = 1'b1; m_due = cyc + int'(LAT);
                m_we = bus.req_we; m_addr = bus.req_addr; m_wd = bus.req_wdata;
            end
        end else if (m_pend) begin
            if (cyc == m_due) begin
                m_pend = 1'b0; m_show = 1'b1;
                m_err  = (m_addr % 4 != 0) || (m_addr >= 32'(DEPTH * 4));
                if (m_err) m_rdata = '0;
                else if (m_we) begin
                    m_mem[m_addr / 4] = m_wd;
                    m_rdata = m_wd;
                end else m_rdata = m_mem[m_addr / 4];
            end
        end else if (m_show && bus.resp_ready) begin
            m_show = 1'b0; m_idle = 1'b1;
        end
    end

    always @(negedge clk) begin
        if (cmp_on) begin
            check("req_ready", 32'(bus.req_ready), 32'(m_idle && !reset));
            check("resp_valid", 32'(bus.resp_valid), 32'(m_show));
            if (m_show) begin
                check("resp_rdata", bus.resp_rdata, m_rdata);
                check("resp_err", 32'(bus.resp_err), 32'(m_err));
            end
        end
    end

    // ---------------- driver helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_req(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                          input int hold, output logic [31:0] rd, output logic er,
                          output int lat);
        int n;
        bit acc;
        n = 0;
        bus.req_valid = 1'b1; bus.req_we = we; bus.req_addr = addr; bus.req_wdata = wd;
        do begin
            acc = bus.req_ready;
            tick();
            n++;
        end while (!acc && n < 40);
        check("accept_timeout", 32'(acc), 32'd1);
        bus.req_valid = 1'b0;
        bus.req_we    = 1'($urandom_range(0, 1));
        bus.req_addr  = $urandom;
        bus.req_wdata = $urandom;
        lat = 0;
        while (!bus.resp_valid && lat < 40) begin
            tick();
            lat++;
        end
        check("resp_timeout", 32'(bus.resp_valid), 32'd1);
        rd = bus.resp_rdata;
        er = bus.resp_err;
        for (int h = 0; h < hold; h++) begin
            tick();
            check("hold_valid", 32'(bus.resp_valid), 32'd1);
            check("hold_rdata", bus.resp_rdata, rd);
            check("hold_err", 32'(bus.resp_err), 32'(er));
            check("hold_req_ready", 32'(bus.req_ready), 32'd0);
        end
        bus.resp_ready = 1'b1;
        tick();
        bus.resp_ready = 1'b0;
    endtask

    function automatic logic [31:0] pick_addr();
        int r;
        logic [31:0] base;
        r = $urandom_range(0, 9);
        base = 32'($urandom_range(0, DEPTH - 1)) * 32'd4;
        if (r < 7)       return base;
        else if (r == 7) return base + 32'($urandom_range(1, 3));
        else if (r == 8) return 32'h100 + base;
        else             return $urandom | 32'h8000_0000;
    endfunction

    logic [31:0] init_data [DEPTH];
    logic [31:0] rd;
    logic        er;
    int          lat;
    int          acc_a [$];
    int          acc_b [$];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; reset_b = 1'b1;
        bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_addr = '0; bus.req_wdata = '0;
        bus.resp_ready = 1'b0;
        bus_b.req_valid = 1'b0; bus_b.req_we = 1'b0; bus_b.req_addr = '0;
        bus_b.req_wdata = '0; bus_b.resp_ready = 1'b0;
        repeat (3) tick();

        check("rst_req_ready", 32'(bus.req_ready), 32'd0);
        check("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
        check("rst_resp_rdata", bus.resp_rdata, 32'd0);
        check("rst_resp_err", 32'(bus.resp_err), 32'd0);
        cmp_on = 1'b1;
        reset = 1'b0;
        tick();
        check("post_rst_req_ready", 32'(bus.req_ready), 32'd1);

        for (int i = 0; i < int'(DEPTH); i++) begin
            init_data[i] = $urandom;
            do_req(1'b1, 32'(i * 4), init_data[i], 0, rd, er, lat);
            check("prefill_echo", rd, init_data[i]);
        end

        // store then load, latency pinned
        do_req(1'b1, 32'h10, 32'hDEAD_BEEF, 0, rd, er, lat);
        check("t1_store_rdata", rd, 32'hDEAD_BEEF);
        check("t1_store_err", 32'(er), 32'd0);
        check("t1_latency", 32'(lat), 32'(LAT));
        do_req(1'b0, 32'h10, 32'h0, 0, rd, er, lat);
        check("t1_load_rdata", rd, 32'hDEAD_BEEF);

        // backpressure
        do_req(1'b0, 32'h10, 32'h0, 5, rd, er, lat);
        check("t2_rdata", rd, 32'hDEAD_BEEF);
        check("t2_ready_after_release", 32'(bus.req_ready), 32'd1);

        // errors
        do_req(1'b1, 32'h12, 32'h5555_5555, 0, rd, er, lat);
        check("t3_misalign_err", 32'(er), 32'd1);
        check("t3_misalign_rdata", rd, 32'd0);
        do_req(1'b0, 32'h10, 32'h0, 0, rd, er, lat);
        check("t3_load_unchanged", rd, 32'hDEAD_BEEF);
        do_req(1'b0, 32'h100, 32'h0, 0, rd, er, lat);
        check("t3_range_err", 32'(er), 32'd1);
        check("t3_range_rdata", rd, 32'd0);

        // reset during WAIT aborts the store
        do_req(1'b1, 32'h20, 32'hCAFE_F00D, 0, rd, er, lat);
        bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_addr = 32'h20; bus.req_wdata = 32'h1234;
        check("t4_ready_before_accept", 32'(bus.req_ready), 32'd1);
        tick();
        bus.req_valid = 1'b0;
        reset = 1'b1;
        tick();
        check("t4_resp_valid_in_reset", 32'(bus.resp_valid), 32'd0);
        reset = 1'b0;
        tick();
        check("t4_idle_after_reset", 32'(bus.req_ready), 32'd1);
        check("t4_resp_valid_after", 32'(bus.resp_valid), 32'd0);
        do_req(1'b0, 32'h20, 32'h0, 0, rd, er, lat);
        check("t4_prior_value", rd, 32'hCAFE_F00D);

        // last word and word 0
        do_req(1'b1, 32'hFC, 32'hA5A5_0FFC, 0, rd, er, lat);
        do_req(1'b0, 32'hFC, 32'h0, 0, rd, er, lat);
        check("t6_last_rdata", rd, 32'hA5A5_0FFC);
        check("t6_last_err", 32'(er), 32'd0);
        do_req(1'b0, 32'h0, 32'h0, 0, rd, er, lat);
        check("t6_word0", rd, init_data[0]);

        // back-to-back on both latencies
        reset_b = 1'b0;
        bus_b.req_valid = 1'b1; bus_b.resp_ready = 1'b1;
        bus.req_valid = 1'b1; bus.req_we = 1'b0; bus.req_addr = 32'h10; bus.resp_ready = 1'b1;
        for (int c = 0; c < 30; c++) begin
            if (bus.req_ready) acc_a.push_back(c);
            if (bus_b.req_ready) acc_b.push_back(c);
            tick();
        end
        bus.req_valid = 1'b0; bus_b.req_valid = 1'b0;
        repeat (6) tick();
        bus.resp_ready = 1'b0;
        check("t5_count_a", 32'(acc_a.size() >= 6), 32'd1);
        check("t5_count_b", 32'(acc_b.size() >= 8), 32'd1);
        for (int i = 1; i < acc_a.size(); i++)
            check("t5_gap_lat2", 32'(acc_a[i] - acc_a[i-1]), 32'(LAT + 2));
        for (int i = 1; i < acc_b.size(); i++)
            check("t5_gap_lat1", 32'(acc_b[i] - acc_b[i-1]), 32'd3);

        // randomized traffic, model checks every cycle
        for (int c = 0; c < 1500; c++) begin
            reset          = ($urandom_range(0, 99) == 0);
            bus.req_valid  = 1'($urandom_range(0, 1));
            bus.req_we     = 1'($urandom_range(0, 1));
            bus.req_addr   = pick_addr();
            bus.req_wdata  = $urandom;
            bus.resp_ready = ($urandom_range(0, 2) != 0);
            tick();
        end
        reset = 1'b0; bus.req_valid = 1'b0; bus.resp_ready = 1'b1;
        repeat (6) tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
